// File: rtl/dsp_dot_seq_if.sv
// Bundle of the dot-product sequencer's operand, slice and result signals.
// Latency: none (wires only).
// Backpressure: carried by in_valid/in_ready and out_valid/out_ready.
interface dsp_dot_seq_if #(
   parameter int LEN_W = 16
);
   // operand stream
   logic             in_valid;
   logic             in_ready;
   logic [17:0]      in_a;
   logic [17:0]      in_b;
   logic             in_last;
   // DSP48A1 slice ports
   logic [17:0]      dsp_A;
   logic [17:0]      dsp_B;
   logic [7:0]       dsp_OPMODE;
   logic [47:0]      dsp_P;
   logic             dsp_CARRYOUT;
   // result
   logic             out_valid;
   logic             out_ready;
   logic [47:0]      out_data;
   logic [LEN_W-1:0] out_len;
`ifdef DOT_OVF_EN
   logic             out_ovf;
`endif

   // environment side: feeds operands, models the slice, consumes results
   modport master (
      output in_valid, in_a, in_b, in_last, dsp_P, dsp_CARRYOUT, out_ready,
`ifdef DOT_OVF_EN
      input  out_ovf,
`endif
      input  in_ready, dsp_A, dsp_B, dsp_OPMODE, out_valid, out_data, out_len
   );

   // sequencer side
   modport slave (
      input  in_valid, in_a, in_b, in_last, dsp_P, dsp_CARRYOUT, out_ready,
`ifdef DOT_OVF_EN
      output out_ovf,
`endif
      output in_ready, dsp_A, dsp_B, dsp_OPMODE, out_valid, out_data, out_len
   );
endinterface

// File: rtl/dsp_dot_seq.sv
// Sequencer/collector for one DSP48A1 unsigned MAC; optional wrap flag out_ovf under macro DOT_OVF_EN.
// Latency: result valid DSP_LAT+1 edges after the last pair is accepted (slice PREG, then capture register).
// Backpressure: in_ready drops from the last pair until the result handshakes; result held while out_ready low.
module dsp_dot_seq #(
   parameter int DSP_LAT  = 3,
   parameter int OPM_SKEW = 1,
   parameter int LEN_W    = 16
) (
   input logic          CLK,
   input logic          RST,
   dsp_dot_seq_if.slave bus
);

   localparam int CNT_W = $clog2(DSP_LAT + 1);
   localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DSP_LAT);

   // OPMODE encodings: X in [1:0], Z in [3:2]
   localparam logic [7:0] OPM_IDLE  = 8'h00;   // X=0, Z=0
   localparam logic [7:0] OPM_FIRST = 8'h01;   // X=M, Z=0: restart the sum
   localparam logic [7:0] OPM_NEXT  = 8'h09;   // X=M, Z=P: accumulate
   localparam logic [7:0] OPM_HOLD  = 8'h08;   // X=0, Z=P: keep P

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   state_t           state;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [47:0]      out_data_r;
   logic [LEN_W-1:0] out_len_r;
   logic [17:0]      a_r;
   logic [17:0]      b_r;
   logic [CNT_W-1:0] drain_cnt;
   logic [LEN_W-1:0] len_cnt;
   logic             accept;
   logic             capture;
   logic [7:0]       opm_slot;
   logic [7:0]       opm_sr [0:OPM_SKEW];

   assign accept  = bus.in_valid & in_ready_r;
   assign capture = (state == DRAIN) && (drain_cnt == '0);

   assign bus.in_ready   = in_ready_r;
   assign bus.dsp_A      = a_r;
   assign bus.dsp_B      = b_r;
   assign bus.dsp_OPMODE = opm_sr[OPM_SKEW];
   assign bus.out_valid  = out_valid_r;
   assign bus.out_data   = out_data_r;
   assign bus.out_len    = out_len_r;

   // Opmode for the slot being issued this cycle; stale A/B in bubbles is masked by X=0.
   always_comb begin
      opm_slot = OPM_IDLE;
      if (accept)
         opm_slot = (state == IDLE) ? OPM_FIRST : OPM_NEXT;
      else if (state == ACCUM || state == DRAIN)
         opm_slot = OPM_HOLD;
   end

   // Delay opmode behind its A/B pair so it meets the slice's OPMODE register at the post-adder stage.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i <= OPM_SKEW; i++)
            opm_sr[i] <= OPM_IDLE;
      end else begin
         opm_sr[0] <= opm_slot;
         for (int i = 1; i <= OPM_SKEW; i++)
            opm_sr[i] <= opm_sr[i-1];
      end
   end

   // Control FSM with registered handshake outputs, operand issue, length count and result capture.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_len_r   <= '0;
         a_r         <= '0;
         b_r         <= '0;
         drain_cnt   <= '0;
         len_cnt     <= '0;
      end else begin
         if (accept) begin
            a_r <= bus.in_a;
            b_r <= bus.in_b;
         end
         case (state)
            IDLE: begin
               in_ready_r <= 1'b1;
               if (accept) begin
                  len_cnt   <= LEN_W'(1);
                  out_len_r <= '0;
                  if (bus.in_last) begin
                     state      <= DRAIN;
                     in_ready_r <= 1'b0;
                     drain_cnt  <= DRAIN_INIT;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  if (len_cnt != '1)
                     len_cnt <= len_cnt + 1'b1;
                  if (bus.in_last) begin
                     state      <= DRAIN;
                     in_ready_r <= 1'b0;
                     drain_cnt  <= DRAIN_INIT;
                  end
               end
            end
            DRAIN: begin
               if (capture) begin
                  state       <= DONE;
                  out_valid_r <= 1'b1;
                  out_data_r  <= bus.dsp_P;
                  out_len_r   <= len_cnt;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DOT_OVF_EN
   logic [DSP_LAT:0] vec_sr;
   logic             ovf_acc;
   logic             out_ovf_r;

   assign bus.out_ovf = out_ovf_r;

   // Track which P cycles carry this vector's sums and collect their carry-outs stickily.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vec_sr    <= '0;
         ovf_acc   <= 1'b0;
         out_ovf_r <= 1'b0;
      end else begin
         vec_sr <= {vec_sr[DSP_LAT-1:0], accept};
         if (accept && state == IDLE) begin
            ovf_acc   <= 1'b0;
            out_ovf_r <= 1'b0;
         end else if (vec_sr[DSP_LAT] && bus.dsp_CARRYOUT) begin
            ovf_acc <= 1'b1;
         end
         if (capture)
            out_ovf_r <= ovf_acc | (vec_sr[DSP_LAT] & bus.dsp_CARRYOUT);
      end
   end
`else
   logic unused_carry;
   assign unused_carry = bus.dsp_CARRYOUT;
`endif

endmodule

// File: tb/tb_dsp_dot_seq.sv
// Bench for dsp_dot_seq with a behavioural DSP48A1 MAC slice and a result scoreboard.
// Latency: checks result arrival DSP_LAT+1 edges after the last pair is accepted.
// Backpressure: exercises input bubbles and a held-off result consumer.
module tb_dsp_dot_seq;
   localparam int DSP_LAT = 3;

   typedef struct {
      logic [47:0] data;
      logic [15:0] len;
      logic        ovf;
   } exp_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   int   cyc;
   int   last_acc;
   logic ov_q;
   exp_t exp_q[$];
   logic [7:0] opm_log[$];

   dsp_dot_seq_if #(.LEN_W(16)) bus_if ();

   dsp_dot_seq #(.DSP_LAT(DSP_LAT), .OPM_SKEW(1), .LEN_W(16)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // slice model: A1/B1 -> M -> P, OPMODE registered, CARRYOUT with P
   logic [17:0] a1 = '0;
   logic [17:0] b1 = '0;
   logic [35:0] m_r = '0;
   logic [7:0]  opm_r = '0;
   logic [47:0] p_r = '0;
   logic        co_r = 1'b0;
   logic [47:0] xsel;
   logic [47:0] zsel;

   always_comb begin
      case (opm_r[1:0])
         2'b01:   xsel = {12'd0, m_r};
         2'b10:   xsel = p_r;
         default: xsel = '0;
      endcase
      zsel = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;
   end

   always @(posedge clk) begin
      a1    <= bus_if.dsp_A;
      b1    <= bus_if.dsp_B;
      m_r   <= a1 * b1;
      opm_r <= bus_if.dsp_OPMODE;
      {co_r, p_r} <= {1'b0, xsel} + {1'b0, zsel};
   end

   assign bus_if.dsp_P        = p_r;
   assign bus_if.dsp_CARRYOUT = co_r;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // monitor: scoreboard pop on result handshake, latency on result rising
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_if.in_valid && bus_if.in_ready && bus_if.in_last)
            last_acc = cyc + 1;
         if (bus_if.out_valid && !ov_q)
            chk("latency", 64'(cyc - last_acc), 64'(DSP_LAT + 1));
         if (bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_out: got data %0d len %0d, expected no result", bus_if.out_data, bus_if.out_len);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_data", 64'(bus_if.out_data), 64'(e.data));
               chk("out_len", 64'(bus_if.out_len), 64'(e.len));
`ifdef DOT_OVF_EN
               chk("out_ovf", 64'(bus_if.out_ovf), 64'(e.ovf));
`endif
            end
         end
      end
      ov_q = rst ? 1'b0 : bus_if.out_valid;
   end

   always @(negedge clk)
      if (bus_if.dsp_OPMODE != 8'h00) opm_log.push_back(bus_if.dsp_OPMODE);

   // called at a negedge; returns at the negedge after the pair is accepted
   task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
      int guard;
      guard = 0;
      bus_if.in_valid = 1'b1;
      bus_if.in_a     = a;
      bus_if.in_b     = b;
      bus_if.in_last  = last;
      while (!bus_if.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: in_ready %0b, expected 1", bus_if.in_ready);
      end
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      bus_if.in_last  = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < budget) begin
         @(negedge clk);
         g++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_opm(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] ex [4];
      logic [7:0] got;
      ex = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++) begin
         got = (opm_log.size() > i) ? opm_log[i] : 8'hFF;
         chk($sformatf("%s_opmode%0d", tag, i), 64'(got), 64'(ex[i]));
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      last_acc = 0;
      ov_q    = 1'b0;
      rst     = 1'b1;
      bus_if.in_valid  = 1'b0;
      bus_if.in_a      = '0;
      bus_if.in_b      = '0;
      bus_if.in_last   = 1'b0;
      bus_if.out_ready = 1'b1;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
      chk("rst_dsp_A", 64'(bus_if.dsp_A), 64'd0);
      chk("rst_dsp_B", 64'(bus_if.dsp_B), 64'd0);
      chk("rst_opmode", 64'(bus_if.dsp_OPMODE), 64'd0);
      chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus_if.out_data), 64'd0);
      chk("rst_out_len", 64'(bus_if.out_len), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // three pairs back to back: 12+30+56
      opm_log.delete();
      exp_q.push_back('{48'd98, 16'd3, 1'b0});
      send(18'd3, 18'd4, 1'b0);
      send(18'd5, 18'd6, 1'b0);
      send(18'd7, 18'd8, 1'b1);
      wait_drain(100);
      chk_opm("vec3", 8'h01, 8'h09, 8'h09, 8'h08);

      // single max pair
      exp_q.push_back('{48'd68718952449, 16'd1, 1'b0});
      send(18'd262143, 18'd262143, 1'b1);
      wait_drain(100);

      // bubble between pairs: 20+30
      opm_log.delete();
      exp_q.push_back('{48'd50, 16'd2, 1'b0});
      send(18'd2, 18'd10, 1'b0);
      @(negedge clk);
      send(18'd3, 18'd10, 1'b1);
      wait_drain(100);
      chk_opm("bubble", 8'h01, 8'h08, 8'h09, 8'h08);

      // consumer stalls for 5 cycles in DONE
      bus_if.out_ready = 1'b0;
      exp_q.push_back('{48'd25, 16'd1, 1'b0});
      send(18'd5, 18'd5, 1'b1);
      for (int g = 0; g < 20 && !bus_if.out_valid; g++) @(negedge clk);
      repeat (5) begin
         chk("stall_out_valid", 64'(bus_if.out_valid), 64'd1);
         chk("stall_out_data", 64'(bus_if.out_data), 64'd25);
         chk("stall_in_ready", 64'(bus_if.in_ready), 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus_if.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_in_ready", 64'(bus_if.in_ready), 64'd1);
      chk("release_out_valid", 64'(bus_if.out_valid), 64'd0);
      wait_drain(50);

      // reset mid-vector, then a fresh one-pair vector
      send(18'd9, 18'd9, 1'b0);
      send(18'd7, 18'd7, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 64'(bus_if.in_ready), 64'd0);
      chk("midrst_opmode", 64'(bus_if.dsp_OPMODE), 64'd0);
      rst = 1'b0;
      exp_q.push_back('{48'd1, 16'd1, 1'b0});
      send(18'd1, 18'd1, 1'b1);
      wait_drain(100);

      // 4097 max products wrap the 48-bit sum: (2^48-2^31+2^12) + (2^36-2^19+1) mod 2^48
      exp_q.push_back('{48'd66571472897, 16'd4097, 1'b1});
      for (int i = 0; i < 4097; i++)
         send(18'd262143, 18'd262143, (i == 4096) ? 1'b1 : 1'b0);
      wait_drain(100);

      // clean vector after the wrap
      exp_q.push_back('{48'd42, 16'd1, 1'b0});
      send(18'd6, 18'd7, 1'b1);
      wait_drain(100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
